// File: rtl/sevseg_scan_mux_if.sv
`default_nettype none
// ============================================================================
// Module      : sevseg_scan_mux_if
// Description : Frame-load handshake bundle for the seven-segment scan mux.
//               The content source drives a full frame of segment codes with
//               a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
interface sevseg_scan_mux_if #(
  parameter int NUM_DIGITS = 4,
  parameter int SEG_W      = 8
) ();
  logic [NUM_DIGITS*SEG_W-1:0] frame_in;
  logic                        frame_valid;
  logic                        frame_ready;

  modport master (output frame_in, output frame_valid, input frame_ready);
  modport slave  (input frame_in, input frame_valid, output frame_ready);
endinterface
`default_nettype wire

// File: rtl/sevseg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : sevseg_scan_mux
// Description : Time-multiplexed N-digit seven-segment driver with dwell
//               timing, PWM brightness, per-digit blanking, one-cycle
//               anti-ghosting dead time and a double-buffered frame that
//               swaps only at the digit-0 boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module sevseg_scan_mux #(
  parameter int               NUM_DIGITS    = 4,
  parameter int               SEG_W         = 8,
  parameter int               SLOT_CYCLES   = 1024,
  parameter int               BRIGHT_W      = 4,
  parameter int               AN_ACTIVE_LOW = 1,
  parameter logic [SEG_W-1:0] SEG_OFF       = '1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  sevseg_scan_mux_if.slave              frame_if,
  input  logic [BRIGHT_W-1:0]           brightness,
  input  logic [NUM_DIGITS-1:0]         blank_mask,
  output logic [SEG_W-1:0]              seg,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_done
);

  localparam int SLOT_W  = $clog2(SLOT_CYCLES);
  localparam int DIG_W   = $clog2(NUM_DIGITS);
  localparam int FRAME_W = NUM_DIGITS * SEG_W;
  localparam logic [NUM_DIGITS-1:0] AN_OFF =
    (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [FRAME_W-1:0] FRAME_OFF = {NUM_DIGITS{SEG_OFF}};

  logic [SLOT_W-1:0]     slot_cnt_q, slot_cnt_d;
  logic [DIG_W-1:0]      digit_idx_q, digit_idx_d;
  logic                  frame_done_q, frame_done_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic [FRAME_W-1:0]    active_q, active_d;
  logic [FRAME_W-1:0]    pending_q, pending_d;
  logic                  pending_full_q, pending_full_d;
  logic                  ready_q, ready_d;
  logic [BRIGHT_W-1:0]   bright_q, bright_d;
  logic                  blank_q, blank_d;

  logic [SEG_W-1:0]      active_digit [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] an_onehot;
  logic [NUM_DIGITS-1:0] an_lit;
  logic [BRIGHT_W-1:0]   phase;
  logic                  slot_last, digit_last, wrap, lit, accept;

  // Per-digit view of the active frame for the segment selector.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_unpack
    assign active_digit[i] = active_q[i*SEG_W +: SEG_W];
  end

  // Scan timing, PWM/blank gating, output selection and double-buffer control.
  always_comb begin
    slot_last  = (slot_cnt_q == SLOT_W'(SLOT_CYCLES - 1));
    digit_last = (digit_idx_q == DIG_W'(NUM_DIGITS - 1));
    wrap       = slot_last && digit_last;

    slot_cnt_d   = slot_last ? '0 : slot_cnt_q + SLOT_W'(1);
    digit_idx_d  = digit_idx_q;
    if (slot_last) begin
      digit_idx_d = digit_last ? '0 : digit_idx_q + DIG_W'(1);
    end
    frame_done_d = wrap;

    // Brightness and blanking are captured once per slot so a change
    // mid-slot cannot produce a partial PWM period.
    bright_d = (slot_cnt_q == '0) ? brightness : bright_q;
    blank_d  = (slot_cnt_q == '0) ? blank_mask[digit_idx_q] : blank_q;

    // Top BRIGHT_W bits of the slot counter form the PWM phase.
    phase = slot_cnt_q[SLOT_W-1 -: BRIGHT_W];
    // Slot cycle 0 is always dark to give the anode switch time to settle.
    lit   = (slot_cnt_q != '0) && !blank_q && ((phase < bright_q) || (&bright_q));

    an_onehot = NUM_DIGITS'(1) << digit_idx_q;
    an_lit    = (AN_ACTIVE_LOW != 0) ? ~an_onehot : an_onehot;
    an_d      = lit ? an_lit : AN_OFF;
    seg_d     = lit ? active_digit[digit_idx_q] : SEG_OFF;

    // Ready is low whenever pending is full, so a load and a swap never
    // coincide; a load on the wrap cycle waits for the following frame.
    accept         = frame_if.frame_valid && ready_q;
    active_d       = active_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    if (accept) begin
      pending_d      = frame_if.frame_in;
      pending_full_d = 1'b1;
    end else if (wrap && pending_full_q) begin
      active_d       = pending_q;
      pending_full_d = 1'b0;
    end
    ready_d = !pending_full_d;
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_cnt_q     <= '0;
      digit_idx_q    <= '0;
      frame_done_q   <= 1'b0;
      an_q           <= AN_OFF;
      seg_q          <= SEG_OFF;
      active_q       <= FRAME_OFF;
      pending_q      <= FRAME_OFF;
      pending_full_q <= 1'b0;
      ready_q        <= 1'b0;
      bright_q       <= '0;
      blank_q        <= 1'b1;
    end else begin
      slot_cnt_q     <= slot_cnt_d;
      digit_idx_q    <= digit_idx_d;
      frame_done_q   <= frame_done_d;
      an_q           <= an_d;
      seg_q          <= seg_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      ready_q        <= ready_d;
      bright_q       <= bright_d;
      blank_q        <= blank_d;
    end
  end

  assign seg                  = seg_q;
  assign an                   = an_q;
  assign digit_idx            = digit_idx_q;
  assign frame_done           = frame_done_q;
  assign frame_if.frame_ready = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_sevseg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_sevseg_scan_mux
// Description : Self-checking bench for sevseg_scan_mux (4 digits, 16-cycle
//               slots, 2-bit brightness, active-low anodes).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sevseg_scan_mux;
  localparam int ND   = 4;
  localparam int SW   = 8;
  localparam int SLOT = 16;
  localparam int BW   = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [BW-1:0] brightness;
  logic [ND-1:0] blank_mask;
  logic [SW-1:0] seg;
  logic [ND-1:0] an;
  logic [1:0]    digit_idx;
  logic          frame_done;

  int checks = 0;
  int errors = 0;

  sevseg_scan_mux_if #(.NUM_DIGITS(ND), .SEG_W(SW)) fif ();

  sevseg_scan_mux #(
    .NUM_DIGITS(ND), .SEG_W(SW), .SLOT_CYCLES(SLOT), .BRIGHT_W(BW),
    .AN_ACTIVE_LOW(1), .SEG_OFF(8'hFF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_if(fif), .brightness(brightness),
    .blank_mask(blank_mask), .seg(seg), .an(an), .digit_idx(digit_idx),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Reference model: time since reset release gives slot and digit directly.
  int         n;
  logic [7:0] m_active [ND];
  logic [7:0] m_pend   [ND];
  bit         m_pend_full;
  int         m_lb;
  bit         m_lblank;
  logic [3:0] exp_an;
  logic [7:0] exp_seg;
  logic       exp_done, exp_ready;
  logic [1:0] exp_digit;

  always @(posedge clk) begin : model
    int s, d, ph;
    bit lit, acc, wrap;
    if (!rst_n) begin
      n = 0;
      for (int i = 0; i < ND; i++) m_active[i] = 8'hFF;
      m_pend_full = 0; m_lb = 0; m_lblank = 1;
      exp_an = 4'hF; exp_seg = 8'hFF; exp_done = 0; exp_ready = 0; exp_digit = 0;
    end else begin
      s = n % SLOT;
      d = (n / SLOT) % ND;
      if (s == 0) begin
        m_lb     = int'(brightness);
        m_lblank = blank_mask[d];
      end
      ph  = s / (SLOT >> BW);
      lit = (s != 0) && !m_lblank && ((ph < m_lb) || (m_lb == (1 << BW) - 1));
      exp_an  = lit ? ~(4'b0001 << d) : 4'hF;
      exp_seg = lit ? m_active[d] : 8'hFF;
      acc  = fif.frame_valid && exp_ready;
      wrap = (s == SLOT - 1) && (d == ND - 1);
      exp_done = wrap;
      if (acc) begin
        for (int i = 0; i < ND; i++) m_pend[i] = fif.frame_in[i*8 +: 8];
        m_pend_full = 1;
      end else if (wrap && m_pend_full) begin
        for (int i = 0; i < ND; i++) m_active[i] = m_pend[i];
        m_pend_full = 0;
      end
      exp_ready = !m_pend_full;
      n++;
      exp_digit = 2'((n / SLOT) % ND);
    end
  end

  task automatic wait_done(input int bound);
    bit seen = 0;
    for (int k = 0; k < bound && !seen; k++) begin
      @(negedge clk);
      if (frame_done === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wait_done: frame_done not seen within %0d cycles", bound);
    end
  endtask

  task automatic load_frame(input logic [31:0] data);
    bit rdy = 0;
    for (int k = 0; k < 100 && !rdy; k++) begin
      if (fif.frame_ready === 1'b1) rdy = 1;
      else @(negedge clk);
    end
    checks++;
    if (!rdy) begin
      errors++;
      $display("FAIL load_ready: frame_ready never rose within 100 cycles");
    end
    fif.frame_in = data; fif.frame_valid = 1'b1;
    @(negedge clk);
    fif.frame_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fif.frame_valid = 1'b0; fif.frame_in = '0;
    brightness = '0; blank_mask = '0;
    repeat (3) @(negedge clk);
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL reset_an: got %h want f", an); end
    checks++; if (seg !== 8'hFF) begin errors++; $display("FAIL reset_seg: got %h want ff", seg); end
    checks++; if (fif.frame_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", fif.frame_ready); end
    checks++; if (digit_idx !== 2'd0) begin errors++; $display("FAIL reset_digit: got %0d want 0", digit_idx); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", frame_done); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (fif.frame_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b want 1", fif.frame_ready); end
  endtask

  task automatic test_scan_order();
    logic [31:0] fa = 32'h92F9A4C0;
    logic [3:0]  oh, ea;
    logic [7:0]  es;
    int s, d;
    brightness = 2'd3; blank_mask = '0;
    load_frame(fa);
    wait_done(200);
    for (int j = 1; j <= 64; j++) begin
      @(negedge clk);
      s = (j - 1) % SLOT; d = (j - 1) / SLOT;
      oh = 4'b0001 << d;
      ea = (s == 0) ? 4'hF : ~oh;
      es = (s == 0) ? 8'hFF : fa[d*8 +: 8];
      checks++; if (an !== ea) begin errors++; $display("FAIL scan_an j=%0d: got %b want %b", j, an, ea); end
      checks++; if (seg !== es) begin errors++; $display("FAIL scan_seg j=%0d: got %h want %h", j, seg, es); end
      checks++; if (frame_done !== 1'(j == 64)) begin errors++; $display("FAIL scan_done j=%0d: got %b", j, frame_done); end
      checks++; if (digit_idx !== 2'((j / SLOT) % ND)) begin errors++; $display("FAIL scan_digit j=%0d: got %0d want %0d", j, digit_idx, (j / SLOT) % ND); end
    end
  endtask

  task automatic test_tear_free();
    logic [31:0] fa = 32'h92F9A4C0;
    logic [31:0] fz = 32'h00000000;
    logic [31:0] cur;
    logic [3:0]  oh, ea;
    logic [7:0]  es;
    int s, d;
    for (int f = 0; f < 2; f++) begin
      cur = (f == 0) ? fa : fz;
      for (int j = 1; j <= 64; j++) begin
        @(negedge clk);
        s = (j - 1) % SLOT; d = (j - 1) / SLOT;
        oh = 4'b0001 << d;
        ea = (s == 0) ? 4'hF : ~oh;
        es = (s == 0) ? 8'hFF : cur[d*8 +: 8];
        checks++; if (an !== ea) begin errors++; $display("FAIL tear_an f=%0d j=%0d: got %b want %b", f, j, an, ea); end
        checks++; if (seg !== es) begin errors++; $display("FAIL tear_seg f=%0d j=%0d: got %h want %h", f, j, seg, es); end
        checks++; if (seg !== exp_seg) begin errors++; $display("FAIL tear_model_seg f=%0d j=%0d: got %h want %h", f, j, seg, exp_seg); end
        if (f == 0) begin
          checks++;
          if (fif.frame_ready !== 1'((j <= 33) || (j == 64))) begin
            errors++; $display("FAIL tear_ready j=%0d: got %b", j, fif.frame_ready);
          end
          if (j == 33) begin fif.frame_valid = 1'b1; fif.frame_in = fz; end
          else if (j == 34) begin fif.frame_valid = 1'b1; fif.frame_in = 32'h12345678; end
          else if (j == 40) fif.frame_valid = 1'b0;
        end
      end
    end
  endtask

  task automatic test_brightness();
    int s, d, lit_cnt;
    bit lit;
    logic [3:0] oh, ea;
    for (int b = 1; b >= 0; b--) begin
      brightness = 2'(b);
      lit_cnt = 0;
      for (int j = 1; j <= 64; j++) begin
        @(negedge clk);
        s = (j - 1) % SLOT; d = (j - 1) / SLOT;
        lit = (b == 1) && (s >= 1) && (s <= 3);
        oh = 4'b0001 << d;
        ea = lit ? ~oh : 4'hF;
        if (an !== 4'hF) lit_cnt++;
        checks++; if (an !== ea) begin errors++; $display("FAIL bright%0d_an j=%0d: got %b want %b", b, j, an, ea); end
        checks++; if (seg !== (lit ? 8'h00 : 8'hFF)) begin errors++; $display("FAIL bright%0d_seg j=%0d: got %h", b, j, seg); end
      end
      checks++;
      if (lit_cnt != ((b == 1) ? 12 : 0)) begin
        errors++; $display("FAIL bright%0d_count: got %0d lit cycles want %0d", b, lit_cnt, (b == 1) ? 12 : 0);
      end
    end
  endtask

  task automatic test_blanking();
    int s, d;
    bit lit;
    logic [3:0] oh, ea;
    brightness = 2'd3; blank_mask = 4'b0100;
    for (int j = 1; j <= 64; j++) begin
      @(negedge clk);
      s = (j - 1) % SLOT; d = (j - 1) / SLOT;
      lit = (s != 0) && (d != 2);
      oh = 4'b0001 << d;
      ea = lit ? ~oh : 4'hF;
      checks++; if (an !== ea) begin errors++; $display("FAIL blank_an j=%0d: got %b want %b", j, an, ea); end
      checks++; if (seg !== (lit ? 8'h00 : 8'hFF)) begin errors++; $display("FAIL blank_seg j=%0d: got %h", j, seg); end
    end
    blank_mask = '0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 640; c++) begin
      @(negedge clk);
      checks++; if (an !== exp_an) begin errors++; $display("FAIL rand_an c=%0d: got %b want %b", c, an, exp_an); end
      checks++; if (seg !== exp_seg) begin errors++; $display("FAIL rand_seg c=%0d: got %h want %h", c, seg, exp_seg); end
      checks++; if (digit_idx !== exp_digit) begin errors++; $display("FAIL rand_digit c=%0d: got %0d want %0d", c, digit_idx, exp_digit); end
      checks++; if (frame_done !== exp_done) begin errors++; $display("FAIL rand_done c=%0d: got %b want %b", c, frame_done, exp_done); end
      checks++; if (fif.frame_ready !== exp_ready) begin errors++; $display("FAIL rand_ready c=%0d: got %b want %b", c, fif.frame_ready, exp_ready); end
      fif.frame_valid = ($urandom_range(3) == 0);
      fif.frame_in    = $urandom;
      brightness      = BW'($urandom);
      if ($urandom_range(7) == 0) blank_mask = ND'($urandom);
    end
    fif.frame_valid = 1'b0; brightness = 2'd3; blank_mask = '0;
  endtask

  task automatic test_midscan_reset();
    bit found = 0;
    int lit_cnt = 0;
    wait_done(200);
    checks++; if (fif.frame_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_pre: got %b want 1", fif.frame_ready); end
    fif.frame_in = 32'h11223344; fif.frame_valid = 1'b1;
    @(negedge clk);
    fif.frame_valid = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      if (digit_idx === 2'd2) found = 1;
      else @(negedge clk);
    end
    checks++; if (!found) begin errors++; $display("FAIL mid_wait_digit2: digit 2 not reached"); end
    repeat (3) @(negedge clk);
    checks++; if (fif.frame_ready !== 1'b0) begin errors++; $display("FAIL mid_pending: got ready %b want 0", fif.frame_ready); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL mid_rst_an: got %b want 1111", an); end
    checks++; if (seg !== 8'hFF) begin errors++; $display("FAIL mid_rst_seg: got %h want ff", seg); end
    checks++; if (digit_idx !== 2'd0) begin errors++; $display("FAIL mid_rst_digit: got %0d want 0", digit_idx); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (digit_idx !== 2'd0) begin errors++; $display("FAIL mid_rel_digit: got %0d want 0", digit_idx); end
    checks++; if (fif.frame_ready !== 1'b1) begin errors++; $display("FAIL mid_rel_ready: got %b want 1", fif.frame_ready); end
    for (int c = 0; c < 140; c++) begin
      @(negedge clk);
      checks++; if (an !== exp_an) begin errors++; $display("FAIL mid_an c=%0d: got %b want %b", c, an, exp_an); end
      if (an !== 4'hF) begin
        lit_cnt++;
        checks++; if (seg !== 8'hFF) begin errors++; $display("FAIL mid_cleared_seg c=%0d: got %h want ff", c, seg); end
      end
    end
    checks++; if (lit_cnt < 100) begin errors++; $display("FAIL mid_lit_count: got %0d want >=100", lit_cnt); end
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_tear_free();
    test_brightness();
    test_blanking();
    test_random();
    test_midscan_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
